// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// The optional return-address stack is enabled by defining PC_RAS_EN.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_REL  = 2'b01,
        PC_REG  = 2'b10,
        PC_TRAP = 2'b11
    } pcsrc_e;

    localparam int INSTR_BYTES = 4;

    // Fetch targets must be word aligned; the two LSBs carry the answer.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pointer names the next free slot, count
// saturates at RAS_DEPTH so a push when full silently drops the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;
    logic [PW-1:0]    top_idx;

    logic             do_replace;
    logic             do_push;
    logic             do_pop;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    assign top_idx = ptr - PW'(1);
    assign empty   = (count == '0);
    assign top     = empty ? '0 : mem[top_idx];

    // Push+pop on a non-empty stack rewrites the top in place; on an empty
    // stack it degrades to a plain push.
    always_comb begin
        do_replace = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        if (en) begin
            if (push && pop && !empty) do_replace = 1'b1;
            else if (push)             do_push    = 1'b1;
            else if (pop && !empty)    do_pop     = 1'b1;
        end
    end

    assign wr_en  = do_replace | do_push;
    assign wr_idx = do_replace ? top_idx : ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_push) begin
            ptr <= ptr + PW'(1);
            if (count != FULL) count <= count + (PW+1)'(1);
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC mux, alignment rejection and PC register.
// Define PC_RAS_EN to build in the return-address stack (pc_ras).
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misalign,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty
);

    pcsrc_e           sel;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] target;
    logic             reject;

    assign sel      = pcsrc_e'(PCsrc);
    assign pc_plus4 = pc + WIDTH'(INSTR_BYTES);
    assign jalr_sum = rs1 + ImmOp;

    always_comb begin
        target = pc_plus4;
        case (sel)
            PC_SEQ:  target = pc_plus4;
            PC_REL:  target = pc + ImmOp;
            PC_REG:  target = {jalr_sum[WIDTH-1:1], 1'b0};
            PC_TRAP: target = trap_vec;
            default: target = pc_plus4;
        endcase
    end

    // Trap vectors come from privileged state and are trusted as-is.
    assign reject = (sel != PC_TRAP) && is_misaligned(target[1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_VECTOR;
            misalign <= 1'b0;
        end else if (en) begin
            if (reject) begin
                misalign <= 1'b1;
            end else begin
                pc       <= target;
                misalign <= 1'b0;
            end
        end
    end

`ifdef PC_RAS_EN
    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty)
    );
`else
    logic unused_ras;
    assign unused_ras = ras_push ^ ras_pop;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queue-based reference model compared every cycle.
module tb_pc_unit;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h100;
    localparam int          D  = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    PCsrc = 2'b00;
    logic [W-1:0]  ImmOp = '0;
    logic [W-1:0]  rs1 = '0;
    logic [W-1:0]  trap_vec = '0;
    logic          ras_push = 1'b0;
    logic          ras_pop = 1'b0;
    logic [W-1:0]  pc;
    logic [W-1:0]  pc_plus4;
    logic          misalign;
    logic [W-1:0]  ras_top;
    logic          ras_empty;

    pc_unit #(.WIDTH(W), .RESET_VECTOR(RV), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en), .PCsrc(PCsrc), .ImmOp(ImmOp), .rs1(rs1),
        .trap_vec(trap_vec), .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc),
        .pc_plus4(pc_plus4), .misalign(misalign), .ras_top(ras_top), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC plus a bounded list of return addresses.
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];
    bit          m_valid = 1'b0;
    logic [31:0] m_t;

    function automatic logic [31:0] m_top();
        return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_pc    = RV;
            m_mis   = 1'b0;
            m_ras.delete();
            m_valid = 1'b1;
        end else if (en && m_valid) begin
            if (RAS_ON) begin
                if (ras_push && ras_pop && m_ras.size() > 0)
                    m_ras[m_ras.size()-1] = m_pc + 4;
                else if (ras_push) begin
                    m_ras.push_back(m_pc + 4);
                    if (m_ras.size() > D) void'(m_ras.pop_front());
                end else if (ras_pop && m_ras.size() > 0)
                    void'(m_ras.pop_back());
            end
            case (PCsrc)
                2'd0:    m_t = m_pc + 4;
                2'd1:    m_t = m_pc + ImmOp;
                2'd2:    m_t = (rs1 + ImmOp) & ~32'h1;
                default: m_t = trap_vec;
            endcase
            if (PCsrc != 2'd3 && (m_t % 4) != 0) m_mis = 1'b1;
            else begin
                m_pc  = m_t;
                m_mis = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
            chk("ras_top", ras_top, m_top());
            chk("ras_empty", {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
        end
    end

    task automatic cyc(input bit e, input logic [1:0] s, input logic [31:0] imm,
                       input logic [31:0] r, input logic [31:0] tv,
                       input bit pu, input bit po, input bit rs);
        en = e; PCsrc = s; ImmOp = imm; rs1 = r; trap_vec = tv;
        ras_push = pu; ras_pop = po; rst = rs;
        @(posedge clk);
        #2;
    endtask

    task automatic seq(input bit pu, input bit po);
        cyc(1'b1, 2'd0, 32'h0, 32'h0, 32'h0, pu, po, 1'b1);
    endtask

    task automatic trap(input logic [31:0] tv);
        cyc(1'b1, 2'd3, 32'h0, 32'h0, tv, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rt(input logic [31:0] v);
        return RAS_ON ? v : 32'h0;
    endfunction

    function automatic logic [31:0] re(input bit e);
        return (RAS_ON ? e : 1'b1) ? 32'h1 : 32'h0;
    endfunction

    initial begin
        @(posedge clk);
        #2;
        chk("reset_pc", pc, 32'h100);
        chk("reset_mis", {31'b0, misalign}, 32'h0);
        chk("reset_empty", {31'b0, ras_empty}, 32'h1);
        chk("reset_top", ras_top, 32'h0);

        seq(0, 0); chk("seq1", pc, 32'h104);
        seq(0, 0); chk("seq2", pc, 32'h108);
        seq(0, 0); chk("seq3", pc, 32'h10C);
        chk("seq_mis", {31'b0, misalign}, 32'h0);

        trap(32'h200); chk("trap", pc, 32'h200);
        cyc(1, 2'd1, 32'hFFFF_FFF8, 0, 0, 0, 0, 1); chk("rel_neg", pc, 32'h1F8);
        cyc(1, 2'd2, 32'h3, 32'h301, 0, 0, 0, 1);   chk("jalr", pc, 32'h304);
        cyc(1, 2'd2, 32'h1, 32'h300, 0, 0, 0, 1);   chk("jalr_bit0", pc, 32'h300);

        trap(32'h40);
        cyc(1, 2'd1, 32'h6, 0, 0, 0, 0, 1);
        chk("rej_pc", pc, 32'h40); chk("rej_mis", {31'b0, misalign}, 32'h1);
        cyc(1, 2'd1, 32'h6, 0, 0, 0, 0, 1);
        chk("rej_again", {31'b0, misalign}, 32'h1);
        seq(0, 0);
        chk("rej_clear_pc", pc, 32'h44); chk("rej_clear_mis", {31'b0, misalign}, 32'h0);
        cyc(1, 2'd2, 32'h0, 32'h42, 0, 0, 0, 1);
        chk("jalr_rej", pc, 32'h44); chk("jalr_rej_mis", {31'b0, misalign}, 32'h1);
        trap(32'h2); chk("trap_unaligned", pc, 32'h2);
        chk("trap_mis", {31'b0, misalign}, 32'h0);
        cyc(1, 2'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1); chk("wrap_rel", pc, 32'h2);
        trap(32'hFFFF_FFFC); seq(0, 0); chk("wrap_seq", pc, 32'h0);

        trap(32'h0);
        for (int i = 0; i < 5; i++) seq(1, 0);
        chk("ras_full_top", ras_top, rt(32'h14));
        seq(0, 1); chk("pop1", ras_top, rt(32'h10));
        seq(0, 1); chk("pop2", ras_top, rt(32'hC));
        seq(0, 1); chk("pop3", ras_top, rt(32'h8));
        seq(0, 1); chk("pop4_empty", {31'b0, ras_empty}, re(1'b1));
        seq(0, 1); chk("pop5_empty", {31'b0, ras_empty}, re(1'b1));
        chk("pop5_top", ras_top, 32'h0);

        trap(32'h78);
        seq(1, 0); seq(1, 0);
        chk("pp_pc", pc, 32'h80);
        seq(1, 1); chk("pushpop_top", ras_top, rt(32'h84));
        seq(0, 1); chk("pushpop_cnt", ras_top, rt(32'h7C));
        seq(0, 1); chk("pushpop_empty", {31'b0, ras_empty}, re(1'b1));
        trap(32'h90);
        seq(1, 1); chk("pp_on_empty", ras_top, rt(32'h94));
        seq(0, 1);

        trap(32'h60);
        seq(1, 0);
        cyc(1, 2'd1, 32'h6, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'd1, 32'h20, 0, 0, 1, 0, 1);
            chk("stall_pc", pc, 32'h64);
            chk("stall_mis", {31'b0, misalign}, 32'h1);
            chk("stall_top", ras_top, rt(32'h64));
        end
        cyc(0, 2'd1, 32'h20, 0, 0, 1, 0, 0);
        chk("stall_rst_pc", pc, 32'h100);
        chk("stall_rst_mis", {31'b0, misalign}, 32'h0);
        chk("stall_rst_empty", {31'b0, ras_empty}, 32'h1);
        seq(0, 0); chk("post_rst", pc, 32'h104);

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
